// File: rtl/cont_campo_bcd.sv
// cont_campo_bcd: up/down field counter for date/time setting screens with a
// run-time limit, load port, wrap pulse and registered two-digit BCD output.
// Optional hold-to-repeat stepping is built when AUTOREPEAT_EN is defined.
module cont_campo_bcd #(
    parameter int             N          = 8,
    parameter int             P          = 2,
    parameter int             W          = 7,
    parameter int             POS_ID     = 0,
    parameter int             MIN_VAL    = 0,
    parameter int             MAX_VAL    = 31,
    parameter logic [N-1:0]   KEY_UP     = N'(8'h75),
    parameter logic [N-1:0]   KEY_DN     = N'(8'h72),
    parameter int             REP_DELAY  = 50,
    parameter int             REP_PERIOD = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [P-1:0] posicion,
    input  logic         en_codigo,
    input  logic         f2,
    input  logic [N-1:0] key_code,
    input  logic [W-1:0] lim_max,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] valor,
    output logic [N-1:0] dato,
    output logic         wrap
);

    localparam logic [W-1:0] MIN_W = W'(MIN_VAL);
    localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

    // Value is always within 0..99, so tens/units fit one nibble each.
    function automatic logic [N-1:0] to_bcd(input logic [W-1:0] v);
        int vi;
        vi = int'(v);
        return N'({4'(vi / 32'sd10), 4'(vi % 32'sd10)});
    endfunction

    logic [W-1:0] emax_s;
    logic [W-1:0] ld_val_s;
    logic [W-1:0] valor_nxt_s;
    logic         wrap_nxt_s;
    logic         sel_s;
    logic         press_s;
    logic         is_up_s;
    logic         is_dn_s;
    logic         rep_step_s;
    logic         step_up_s;
    logic         step_dn_s;
    logic         en_q_r;
    logic [W-1:0] valor_r;
    logic [N-1:0] dato_r;
    logic         wrap_r;

    assign sel_s     = f2 && (posicion == P'(POS_ID));
    assign press_s   = sel_s && en_codigo && !en_q_r;
    assign is_up_s   = (key_code == KEY_UP);
    assign is_dn_s   = (key_code == KEY_DN);
    assign step_up_s = (press_s || rep_step_s) && is_up_s;
    assign step_dn_s = (press_s || rep_step_s) && is_dn_s;

`ifdef AUTOREPEAT_EN
    localparam int             CW         = W + 8;
    localparam logic [CW-1:0]  REP_AT     = CW'(REP_DELAY);
    localparam logic [CW-1:0]  REP_RELOAD = CW'(REP_DELAY - REP_PERIOD + 1);

    logic [CW-1:0] hold_cnt_r;
    logic [N-1:0]  key_q_r;
    logic          hold_s;

    assign hold_s     = sel_s && en_codigo && en_q_r && (key_code == key_q_r)
                        && (is_up_s || is_dn_s);
    assign rep_step_s = hold_s && (hold_cnt_r == REP_AT);

    // Hold counter: counts cycles since the press; reloads so later repeats come every REP_PERIOD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_r <= {CW{1'b0}};
            key_q_r    <= {N{1'b0}};
        end else begin
            key_q_r <= key_code;
            if (press_s) begin
                hold_cnt_r <= CW'(1);
            end else if (rep_step_s) begin
                hold_cnt_r <= REP_RELOAD;
            end else if (hold_s) begin
                hold_cnt_r <= hold_cnt_r + CW'(1);
            end else begin
                hold_cnt_r <= {CW{1'b0}};
            end
        end
    end
`else
    // Repeat timing has no effect in this build; the term is constant zero.
    assign rep_step_s = (REP_DELAY < 0) && (REP_PERIOD < 0);
`endif

    // Effective upper bound: run-time limit capped by MAX_VAL, never below MIN_VAL.
    always_comb begin
        if ({1'b1, lim_max} < {1'b1, MIN_W}) begin
            emax_s = MIN_W;
        end else if (lim_max > MAX_W) begin
            emax_s = MAX_W;
        end else begin
            emax_s = lim_max;
        end
    end

    // Load value clamped into [MIN_VAL, emax].
    always_comb begin
        if ({1'b1, load_val} < {1'b1, MIN_W}) begin
            ld_val_s = MIN_W;
        end else if (load_val > emax_s) begin
            ld_val_s = emax_s;
        end else begin
            ld_val_s = load_val;
        end
    end

    // Next value: load, then clamp, then a key step; only steps can wrap.
    always_comb begin
        valor_nxt_s = valor_r;
        wrap_nxt_s  = 1'b0;
        if (load) begin
            valor_nxt_s = ld_val_s;
        end else if (valor_r > emax_s) begin
            valor_nxt_s = emax_s;
        end else if (step_up_s) begin
            if (valor_r == emax_s) begin
                valor_nxt_s = MIN_W;
                wrap_nxt_s  = 1'b1;
            end else begin
                valor_nxt_s = valor_r + W'(1);
            end
        end else if (step_dn_s) begin
            if (valor_r == MIN_W) begin
                valor_nxt_s = emax_s;
                wrap_nxt_s  = 1'b1;
            end else begin
                valor_nxt_s = valor_r - W'(1);
            end
        end else begin
            valor_nxt_s = valor_r;
        end
    end

    // State and outputs; BCD is taken from the next value so both change together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valor_r <= MIN_W;
            dato_r  <= to_bcd(MIN_W);
            wrap_r  <= 1'b0;
            en_q_r  <= 1'b0;
        end else begin
            valor_r <= valor_nxt_s;
            dato_r  <= to_bcd(valor_nxt_s);
            wrap_r  <= wrap_nxt_s;
            en_q_r  <= en_codigo;
        end
    end

    assign valor = valor_r;
    assign dato  = dato_r;
    assign wrap  = wrap_r;

endmodule
